// File: rtl/alu_seq.sv
// Sequencing controller for the 20-bit ALU: valid/ready in, one- or multi-cycle execute, valid/ready out, {C,S,Z} status.
// Define ALU_SEQ_MSHIFT_EN for multi-bit shifts/rotates; otherwise every shift/rotate moves one position.
module alu_seq #(
   parameter int MAX_AMT = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [3:0]  op,
   input  logic        mode,
   input  logic [19:0] a,
   input  logic [19:0] b,
   input  logic [4:0]  amt,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [19:0] res,
   output logic        res_wr,
   output logic        zero,
   output logic        sign,
   output logic        carry,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [3:0] OP_NOP = 4'd0,  OP_NOT = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4,  OP_SHR = 4'd5,  OP_SHL = 4'd6,  OP_ROR = 4'd7;
   localparam logic [3:0] OP_ROL = 4'd8,  OP_INC = 4'd9,  OP_DEC = 4'd10, OP_ADD = 4'd11;
   localparam logic [3:0] OP_SUB = 4'd12, OP_CMP = 4'd13, OP_LDS = 4'd14, OP_XRS = 4'd15;

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic        mode_q, mode_d;
   logic [19:0] x_q, x_d;
   logic [19:0] b_q, b_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        amt0_q, amt0_d;
   logic [19:0] res_q, res_d;
   logic        wr_q, wr_d;
   logic        z_q, z_d, s_q, s_d, c_q, c_d;

   logic [4:0]  n_load;
   logic        amt0_load;

`ifdef ALU_SEQ_MSHIFT_EN
   localparam logic [4:0] AMT_LIM = 5'(MAX_AMT);
   logic [4:0] amt_sat;
   logic       is_shift_in;
   always_comb begin
      is_shift_in = (op >= OP_SHR) && (op <= OP_ROL);
      amt_sat     = (amt > AMT_LIM) ? AMT_LIM : amt;
      n_load      = (is_shift_in && amt_sat != 5'd0) ? amt_sat : 5'd1;
      amt0_load   = is_shift_in && (amt == 5'd0);
   end
`else
   // Single-step build: the shift count has no effect.
   logic unused_amt;
   assign unused_amt = ^amt;
   assign n_load     = 5'd1;
   assign amt0_load  = 1'b0;
`endif

   // One-position shift/rotate step on the working register.
   logic [19:0] step_x;
   logic        step_out;
   always_comb begin
      step_x   = x_q;
      step_out = 1'b0;
      case (op_q)
         OP_SHR: begin step_x = {x_q[18:0], 1'b0};  step_out = x_q[19]; end
         OP_SHL: begin step_x = {1'b0, x_q[19:1]};  step_out = x_q[0];  end
         OP_ROR:       step_x = {x_q[18:0], x_q[19]};
         OP_ROL:       step_x = {x_q[0], x_q[19:1]};
         default: ;
      endcase
   end

   logic [19:0] aw, bw, mask, alu_r;
   logic [20:0] sum21;
   logic        alu_c, alu_z, alu_s;
   always_comb begin
      mask  = mode_q ? 20'hFFFFF : 20'h003FF;
      aw    = x_q & mask;
      bw    = b_q & mask;
      sum21 = 21'd0;
      alu_r = 20'd0;
      alu_c = c_q;
      case (op_q)
         OP_NOT: alu_r = ~aw & mask;
         OP_AND: alu_r = aw & bw;
         OP_OR:  alu_r = aw | bw;
         OP_XOR: alu_r = aw ^ bw;
         OP_INC: begin
            sum21 = {1'b0, aw} + 21'd1;
            alu_r = sum21[19:0] & mask;
            alu_c = mode_q ? sum21[20] : sum21[10];
         end
         OP_DEC: begin
            sum21 = {1'b0, aw} - 21'd1;
            alu_r = sum21[19:0] & mask;
            alu_c = (aw == 20'd0);
         end
         OP_ADD: begin
            sum21 = {1'b0, aw} + {1'b0, bw};
            alu_r = sum21[19:0] & mask;
            alu_c = mode_q ? sum21[20] : sum21[10];
         end
         OP_SUB: begin
            sum21 = {1'b0, aw} + {1'b0, ~bw & mask} + 21'd1;
            alu_r = sum21[19:0] & mask;
            alu_c = (aw < bw);
         end
         default: ;
      endcase
      alu_z = (alu_r == 20'd0);
      alu_s = mode_q ? alu_r[19] : alu_r[9];
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      mode_d  = mode_q;
      x_d     = x_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      amt0_d  = amt0_q;
      res_d   = res_q;
      wr_d    = wr_q;
      z_d     = z_q;
      s_d     = s_q;
      c_d     = c_q;
      case (state_q)
         IDLE: begin
            if (op_valid) begin
               state_d = EXEC;
               op_d    = op;
               mode_d  = mode;
               x_d     = a;
               b_d     = b;
               cnt_d   = n_load;
               amt0_d  = amt0_load;
            end
         end
         EXEC: begin
            if (op_q >= OP_SHR && op_q <= OP_ROL) begin
               if (amt0_q) begin
                  state_d = DONE;
                  res_d   = x_q;
                  wr_d    = 1'b1;
                  z_d     = (x_q == 20'd0);
                  s_d     = x_q[19];
               end else begin
                  x_d   = step_x;
                  cnt_d = cnt_q - 5'd1;
                  if (cnt_q == 5'd1) begin
                     state_d = DONE;
                     res_d   = step_x;
                     wr_d    = 1'b1;
                     z_d     = (step_x == 20'd0);
                     s_d     = step_x[19];
                     if (op_q == OP_SHR || op_q == OP_SHL) c_d = step_out;
                  end
               end
            end else begin
               state_d = DONE;
               res_d   = 20'd0;
               wr_d    = 1'b0;
               case (op_q)
                  OP_NOP: ;
                  OP_CMP: begin z_d = (aw == bw); s_d = (aw < bw); end
                  OP_LDS: {c_d, s_d, z_d} = x_q[2:0];
                  OP_XRS: {c_d, s_d, z_d} = {c_q, s_q, z_q} ^ x_q[2:0];
                  default: begin
                     res_d = alu_r;
                     wr_d  = 1'b1;
                     z_d   = alu_z;
                     s_d   = alu_s;
                     c_d   = alu_c;
                  end
               endcase
            end
         end
         DONE: if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_NOP;
         mode_q  <= 1'b0;
         x_q     <= 20'd0;
         b_q     <= 20'd0;
         cnt_q   <= 5'd0;
         amt0_q  <= 1'b0;
         res_q   <= 20'd0;
         wr_q    <= 1'b0;
         z_q     <= 1'b0;
         s_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mode_q  <= mode_d;
         x_q     <= x_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         amt0_q  <= amt0_d;
         res_q   <= res_d;
         wr_q    <= wr_d;
         z_q     <= z_d;
         s_q     <= s_d;
         c_q     <= c_d;
      end
   end

   assign op_ready  = (state_q == IDLE);
   assign res_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign res       = res_q;
   assign res_wr    = wr_q;
   assign zero      = z_q;
   assign sign      = s_q;
   assign carry     = c_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencing controller for the 20-bit ALU datapath. It accepts one operation at a time over a valid/ready handshake and latches the operands. It runs the operation for one cycle, or iteratively for multi-bit shifts and rotates. It then returns the result over a second valid/ready handshake and owns the 3-bit status register {carry, sign, zero} that the program-flow jump logic reads.

## Interface
- MAX_AMT, 20: saturation limit for the shift/rotate amount; values above it are treated as MAX_AMT.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  request valid.
- op_ready  out  1  high only in IDLE.
- op  in  4  opcode:
  - 0 NOP, 1 NOT, 2 AND, 3 OR, 4 XOR
  - 5 SHR, 6 SHL, 7 ROTR, 8 ROTL
  - 9 INC, 10 DEC, 11 ADD, 12 SUB
  - 13 CMP, 14 LDS, 15 XRS
- mode  in  1  1 = full word (20 bits), 0 = half word (bits [9:0]).
- a, b  in  20  operands.
- amt  in  5  shift/rotate count.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res  out  20  result word.
- res_wr  out  1  1 when res is to be written back. 0 for NOP, CMP, LDS and XRS.
- zero, sign, carry  out  1 each  status register bits.
- busy  out  1  high in EXEC or DONE.

## Operation
- States:
  - IDLE: op_ready=1.
  - EXEC: N step cycles.
  - DONE: res_valid=1.
- Transitions:
  - IDLE→EXEC on op_valid&&op_ready. Operands, op and mode are latched on that edge.
  - EXEC→DONE after the Nth step.
  - DONE→IDLE on res_ready.
- N = 1 for all non-shift ops. For shifts and rotates, N = max(min(amt,MAX_AMT),1).
- Half-word mode applies to logic and arithmetic ops:
  - The op is computed on [9:0]; res[19:10]=0.
  - S = res[9]; C is taken from bit 10 of the operation.
- Full-word mode: S = res[19]; C is taken from bit 20.
- In both modes, Z = 1 when the active width is all zero.
- Logic ops (NOT, AND, OR, XOR): update Z and S; C is unchanged.
- Arithmetic ops:
  - ADD/INC: C = carry out.
  - SUB/DEC: C = borrow, i.e. a<b for SUB and a==0 for DEC.
  - SUB is a + ~b + 1.
- Shifts and rotates always use the full 20 bits; mode is ignored. One bit position moves per EXEC cycle:
  - SHR: {x[18:0],0}, C=x[19].
  - SHL: {0,x[19:1]}, C=x[0].
  - ROTR: {x[18:0],x[19]}.
  - ROTL: {x[0],x[19:1]}.
  - SHR/SHL: C = the last bit shifted out.
  - ROTR/ROTL: C unchanged.
  - amt=0: res=a in one cycle; Z and S updated; C unchanged.
- CMP: Z = (a==b), S = (a<b) unsigned, both in the active width. C unchanged. res=0.
- LDS: {C,S,Z} <= a[2:0]. XRS: {C,S,Z} <= {C,S,Z}^a[2:0]. res=0.
- NOP: no flag change; res=0.
- The status register and res update on the edge that enters DONE. Both are held until the next op completes.

## Timing
- Reset values:
  - State: IDLE.
  - op_ready 1; res_valid 0, res 0, res_wr 0.
  - zero, sign, carry 0; busy 0.
- Latency: res_valid is first high N cycles after the accept edge. Non-shift ops give res_valid in the cycle right after acceptance.
- res, res_wr and the flags stay stable while res_valid=1 and res_ready=0.
- op_valid outside IDLE is ignored. Requesters hold their request until op_ready.
- If res_ready is already high on DONE entry, the result is consumed on the next edge. A new op is accepted at the earliest one cycle later. Throughput is one op per N+2 cycles.
- Reset in mid-EXEC or in DONE aborts the op:
  - The result is discarded.
  - Flags clear to 0.
  - op_ready=1 in the following cycle.
- Operand inputs changing during EXEC have no effect.

## Configuration
- ALU_SEQ_MSHIFT_EN:
  - Defined: multi-bit shift/rotate is used, as above; N = max(min(amt,MAX_AMT),1).
  - Undefined: amt is ignored. Every shift/rotate moves one position with N=1, and amt=0 is not special.

## Test plan
- Full ADD, a=0xFFFFF, b=0x00001 -> res=0x00000, Z=1, S=0, C=1, res_wr=1; res_valid 1 cycle after accept.
- Half ADD, a=0x003FF, b=0x00001 -> res=0x00000, Z=1, C=1. Half SUB, a=0x00003, b=0x00005 -> res=0x003FE, S=1, C=1.
- SHR, amt=3, a=0x80001 (MSHIFT_EN) -> res=0x00008, C=0; res_valid 3 cycles after accept. ROTL, amt=4, a=0x0000F -> res=0xF0000.
- CMP, a=5, b=9 after a carry-setting ADD -> Z=0, S=1, C=1 kept, res_wr=0. LDS a=0x5 then XRS a=0x7 -> {C,S,Z}=010.
- Backpressure: hold res_ready=0 for 5 cycles after DONE, with op_valid=1 throughout -> res and flags stable, op_ready=0, no second accept; accept occurs 1 cycle after the res handshake.
- Reset asserted in the 4th EXEC cycle of SHL, amt=10 -> next cycle res_valid=0, flags=000, op_ready=1; a following NOT, full, a=0 -> res=0xFFFFF, S=1, Z=0.
